// File: rtl/mult_accum.sv
// Streaming multiply-accumulate: accepts a burst of operand pairs, registers
// each product, sums them into a wide accumulator and hands off the total.

module mult #(
  parameter bit IS_SIGNED = 1'b0,
  parameter int WIDTH     = 16
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_p
);
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;

  // The low 2*WIDTH bits of the product of extended operands are exact for both signednesses.
  generate
    if (IS_SIGNED) begin : g_signed
      assign w_a_ext = {{WIDTH{i_a[WIDTH-1]}}, i_a};
      assign w_b_ext = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    end else begin : g_unsigned
      assign w_a_ext = {{WIDTH{1'b0}}, i_a};
      assign w_b_ext = {{WIDTH{1'b0}}, i_b};
    end
  endgenerate

  assign o_p = w_a_ext * w_b_ext;
endmodule

module mult_accum #(
  parameter bit IS_SIGNED   = 1'b0,
  parameter int INPUT_WIDTH = 16,
  parameter int ACC_WIDTH   = 2*INPUT_WIDTH + 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_WIDTH-1:0] in0,
  input  logic [INPUT_WIDTH-1:0] in1,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   result,
  output logic                   busy
);
  localparam int PW = 2*INPUT_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic [PW-1:0]          r_product;
  logic                   r_product_v;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [PW-1:0]          w_product;
  logic [ACC_WIDTH-1:0]   w_product_ext;
  logic                   w_accept;
  logic                   w_last;

  mult #(
    .IS_SIGNED (IS_SIGNED),
    .WIDTH     (INPUT_WIDTH)
  ) u_mult (
    .i_a (in0),
    .i_b (in1),
    .o_p (w_product)
  );

  generate
    if (ACC_WIDTH == PW) begin : g_ext_none
      assign w_product_ext = r_product;
    end else if (IS_SIGNED) begin : g_ext_sign
      assign w_product_ext = {{(ACC_WIDTH-PW){r_product[PW-1]}}, r_product};
    end else begin : g_ext_zero
      assign w_product_ext = {{(ACC_WIDTH-PW){1'b0}}, r_product};
    end
  endgenerate

  assign w_accept = in_valid && in_ready;
  assign w_last   = w_accept && (r_remaining == COUNT_WIDTH'(1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (go) w_next_state = (count == '0) ? S_DONE : S_ACCUM;
      S_ACCUM: if (w_last) w_next_state = S_DRAIN;
      S_DRAIN: w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_ACCUM);
    out_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_remaining <= '0;
      r_product   <= '0;
      r_product_v <= 1'b0;
      r_acc       <= '0;
    end else begin
      r_product_v <= w_accept;
      if (w_accept) begin
        r_product   <= w_product;
        r_remaining <= r_remaining - COUNT_WIDTH'(1);
      end
      // Starting a burst clears the sum; otherwise add the product registered last cycle.
      if ((r_state == S_IDLE) && go) begin
        r_remaining <= count;
        r_acc       <= '0;
      end else if (r_product_v) begin
        r_acc <= r_acc + w_product_ext;
      end
    end
  end

  assign result = r_acc;
endmodule

// File: tb/tb_mult_accum.sv
// Directed bench for mult_accum: unsigned, signed and narrow-accumulator
// instances exercised with hand-computed sums, gaps, backpressure and reset.

module tb_mult_accum;
  logic       clk = 1'b0;
  logic       rst;
  logic       go_u, go_s, go_w;
  logic [7:0] count;
  logic       in_valid;
  logic [7:0] in0, in1;
  logic       out_ready;

  logic        u_in_ready, u_out_valid, u_busy;
  logic [23:0] u_result;
  logic        s_in_ready, s_out_valid, s_busy;
  logic [23:0] s_result;
  logic        w_in_ready, w_out_valid, w_busy;
  logic [15:0] w_result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_accum #(.IS_SIGNED(1'b0), .INPUT_WIDTH(8), .ACC_WIDTH(24), .COUNT_WIDTH(8)) u_uns (
    .clk(clk), .rst(rst), .go(go_u), .count(count), .in_valid(in_valid),
    .in_ready(u_in_ready), .in0(in0), .in1(in1), .out_valid(u_out_valid),
    .out_ready(out_ready), .result(u_result), .busy(u_busy));

  mult_accum #(.IS_SIGNED(1'b1), .INPUT_WIDTH(8), .ACC_WIDTH(24), .COUNT_WIDTH(8)) u_sgn (
    .clk(clk), .rst(rst), .go(go_s), .count(count), .in_valid(in_valid),
    .in_ready(s_in_ready), .in0(in0), .in1(in1), .out_valid(s_out_valid),
    .out_ready(out_ready), .result(s_result), .busy(s_busy));

  mult_accum #(.IS_SIGNED(1'b0), .INPUT_WIDTH(8), .ACC_WIDTH(16), .COUNT_WIDTH(8)) u_wrap (
    .clk(clk), .rst(rst), .go(go_w), .count(count), .in_valid(in_valid),
    .in_ready(w_in_ready), .in0(in0), .in1(in1), .out_valid(w_out_valid),
    .out_ready(out_ready), .result(w_result), .busy(w_busy));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in0      = a;
    in1      = b;
    step();
  endtask

  initial begin
    logic       gap_v[7];
    logic [7:0] gap_a[7];
    logic [7:0] gap_b[7];
    gap_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    gap_a = '{8'd1, 8'd99, 8'd99, 8'd3, 8'd10, 8'd99, 8'd7};
    gap_b = '{8'd2, 8'd99, 8'd99, 8'd4, 8'd10, 8'd99, 8'd9};

    rst = 1'b1; go_u = 1'b0; go_s = 1'b0; go_w = 1'b0; count = '0;
    in_valid = 1'b0; in0 = '0; in1 = '0; out_ready = 1'b1;
    step();
    step();
    check("rst_in_ready", 64'(u_in_ready), 64'd0);
    check("rst_out_valid", 64'(u_out_valid), 64'd0);
    check("rst_busy", 64'(u_busy), 64'd0);
    check("rst_result", 64'(u_result), 64'd0);
    rst = 1'b0;
    step();

    // Unsigned burst with backpressure and ignored go.
    out_ready = 1'b0;
    count = 8'd3; go_u = 1'b1;
    step();
    go_u = 1'b0; count = 8'd7;
    check("start_in_ready", 64'(u_in_ready), 64'd1);
    check("start_busy", 64'(u_busy), 64'd1);
    send(8'd3, 8'd4);
    send(8'd5, 8'd6);
    send(8'd255, 8'd255);
    in_valid = 1'b0;
    check("drain_in_ready", 64'(u_in_ready), 64'd0);
    check("drain_out_valid", 64'(u_out_valid), 64'd0);
    step();
    check("uns_out_valid", 64'(u_out_valid), 64'd1);
    check("uns_result", 64'(u_result), 64'd65067);
    for (int i = 0; i < 10; i++) begin
      go_u = (i == 3);
      step();
      check("bp_out_valid", 64'(u_out_valid), 64'd1);
      check("bp_result", 64'(u_result), 64'd65067);
    end
    go_u = 1'b1; count = 8'd2; out_ready = 1'b1;
    step();
    check("handshake_out_valid", 64'(u_out_valid), 64'd0);
    check("go_on_f_ignored", 64'(u_busy), 64'd0);
    go_u = 1'b0;
    step();
    check("idle_stays", 64'(u_busy), 64'd0);

    // Signed burst; go/count pulsed mid-ACCUM must not disturb it.
    count = 8'd2; go_s = 1'b1;
    step();
    go_s = 1'b0;
    send(8'hFD, 8'd7);
    go_s = 1'b1; count = 8'd0;
    send(8'h80, 8'h80);
    go_s = 1'b0; in_valid = 1'b0;
    step();
    check("sgn_out_valid", 64'(s_out_valid), 64'd1);
    check("sgn_result", 64'(s_result), 64'd16363);
    step();
    check("sgn_idle", 64'(s_busy), 64'd0);

    count = 8'd1; go_s = 1'b1;
    step();
    go_s = 1'b0;
    send(8'hFF, 8'h01);
    in_valid = 1'b0;
    step();
    check("sgn_neg_one", 64'(s_result), 64'hFF_FFFF);
    step();

    // Zero-length burst.
    count = 8'd0; go_u = 1'b1;
    step();
    go_u = 1'b0;
    check("zero_out_valid", 64'(u_out_valid), 64'd1);
    check("zero_result", 64'(u_result), 64'd0);
    check("zero_in_ready", 64'(u_in_ready), 64'd0);
    step();
    check("zero_idle", 64'(u_out_valid), 64'd0);

    // Gapped input: 4 accepts out of 7 cycles, extra valid after the last is refused.
    count = 8'd4; go_u = 1'b1;
    step();
    go_u = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = gap_v[i]; in0 = gap_a[i]; in1 = gap_b[i];
      step();
    end
    check("gap_in_ready_low", 64'(u_in_ready), 64'd0);
    send(8'd50, 8'd50);
    in_valid = 1'b0;
    check("gap_out_valid", 64'(u_out_valid), 64'd1);
    check("gap_result", 64'(u_result), 64'd177);
    step();

    // Reset after 2 of 5 accepts, then a clean single-pair burst.
    count = 8'd5; go_u = 1'b1;
    step();
    go_u = 1'b0;
    send(8'd9, 8'd9);
    send(8'd8, 8'd8);
    rst = 1'b1;
    step();
    check("mid_rst_in_ready", 64'(u_in_ready), 64'd0);
    check("mid_rst_out_valid", 64'(u_out_valid), 64'd0);
    check("mid_rst_busy", 64'(u_busy), 64'd0);
    check("mid_rst_result", 64'(u_result), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    count = 8'd1; go_u = 1'b1;
    step();
    go_u = 1'b0;
    send(8'd2, 8'd3);
    in_valid = 1'b0;
    step();
    check("fresh_out_valid", 64'(u_out_valid), 64'd1);
    check("fresh_result", 64'(u_result), 64'd6);
    step();

    // 16-bit accumulator wraps modulo 2^16.
    count = 8'd2; go_w = 1'b1;
    step();
    go_w = 1'b0;
    send(8'd255, 8'd255);
    send(8'd255, 8'd255);
    in_valid = 1'b0;
    step();
    check("wrap_out_valid", 64'(w_out_valid), 64'd1);
    check("wrap_result", 64'(w_result), 64'd64514);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
